// File: rtl/base_hps_pio_pkg.sv
// Shared constants for the HPS parallel I/O ports: the Avalon word-address
// map and the edge-type encodings for the input PIO.
package base_hps_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_MASK = 2'd1;
  localparam logic [1:0] PIO_ADDR_RSVD = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

  localparam int PIO_EDGE_RISE = 0;
  localparam int PIO_EDGE_FALL = 1;
  localparam int PIO_EDGE_ANY  = 2;

endpackage

// File: rtl/pio_in_sync.sv
// Input synchronizer for the PIO input port: a SYNC_STAGES-deep flop chain per
// bit, a one-cycle delayed copy of the synchronized value, and per-bit edge
// detection selected at elaboration time by EDGE_TYPE.
module pio_in_sync
  import base_hps_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = PIO_EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] edge_det
);

  logic [WIDTH-1:0] sync_reg [SYNC_STAGES];
  logic [WIDTH-1:0] prev_reg;

  // Shift the asynchronous inputs through the chain and keep last cycle's output;
  // reset empties the chain so in-flight edges are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= '0;
      end
      prev_reg <= '0;
    end else begin
      sync_reg[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign sync_out = sync_reg[SYNC_STAGES-1];

  // Per-bit edge detector; only the selected edge flavour is built.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_det
      if (EDGE_TYPE == PIO_EDGE_RISE) begin : g_rise
        assign edge_det[gi] = sync_out[gi] & ~prev_reg[gi];
      end else if (EDGE_TYPE == PIO_EDGE_FALL) begin : g_fall
        assign edge_det[gi] = ~sync_out[gi] & prev_reg[gi];
      end else begin : g_any
        assign edge_det[gi] = sync_out[gi] ^ prev_reg[gi];
      end
    end
  endgenerate

endmodule

// File: rtl/base_hps_pio_in.sv
// Avalon-MM parallel input port for the HPS lightweight bridge: synchronized
// data register, per-bit edge capture with write-1-to-clear, interrupt mask and
// a level interrupt. Read data is registered with a latency of one cycle.
module base_hps_pio_in
  import base_hps_pio_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter int               SYNC_STAGES  = 2,
  parameter int               EDGE_TYPE    = PIO_EDGE_RISE,
  parameter logic [WIDTH-1:0] IRQ_MASK_RST = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] edge_det;

  logic [WIDTH-1:0] irq_mask_reg;
  logic [WIDTH-1:0] irq_mask_next;
  logic [WIDTH-1:0] edge_capture_reg;
  logic [WIDTH-1:0] edge_capture_next;
  logic [WIDTH-1:0] edge_clr;
  logic [31:0]      readdata_reg;
  logic [31:0]      readdata_next;

  logic wr_en;
  logic rd_en;
  logic unused_wdata;

  pio_in_sync #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .in_port (in_port),
    .sync_out(sync_out),
    .edge_det(edge_det)
  );

  assign wr_en = chipselect & ~write_n;
  assign rd_en = chipselect & ~read_n;

  // Upper writedata bits beyond WIDTH carry no meaning for this port.
  assign unused_wdata = ^writedata;

  // Next-state for mask and edge capture; a fresh edge beats a clear on the same bit.
  always_comb begin
    edge_clr          = '0;
    irq_mask_next     = irq_mask_reg;
    if (wr_en && (address == PIO_ADDR_EDGE)) begin
      edge_clr = writedata[WIDTH-1:0];
    end
    if (wr_en && (address == PIO_ADDR_MASK)) begin
      irq_mask_next = writedata[WIDTH-1:0];
    end
    edge_capture_next = edge_det | (edge_capture_reg & ~edge_clr);
  end

  // Read mux built from current register contents, so a same-cycle write is not visible.
  always_comb begin
    readdata_next = readdata_reg;
    if (rd_en) begin
      readdata_next = '0;
      case (address)
        PIO_ADDR_DATA: readdata_next[WIDTH-1:0] = sync_out;
        PIO_ADDR_MASK: readdata_next[WIDTH-1:0] = irq_mask_reg;
        PIO_ADDR_EDGE: readdata_next[WIDTH-1:0] = edge_capture_reg;
        default:       readdata_next = '0;
      endcase
    end
  end

  // Register file update.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask_reg     <= IRQ_MASK_RST;
      edge_capture_reg <= '0;
      readdata_reg     <= '0;
    end else begin
      irq_mask_reg     <= irq_mask_next;
      edge_capture_reg <= edge_capture_next;
      readdata_reg     <= readdata_next;
    end
  end

  assign readdata = readdata_reg;
  assign irq      = |(edge_capture_reg & irq_mask_reg);

endmodule

// File: tb/tb_base_hps_pio_in.sv
// Bench for base_hps_pio_in: two instances (rising-edge and any-edge) share one
// bus and one input bus. A reference model predicts read data and irq; a
// monitor compares them as the DUTs present results.
module tb_base_hps_pio_in;

  localparam int         W        = 8;
  localparam int         S        = 2;
  localparam logic [7:0] MRST_ANY = 8'h5A;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [W-1:0] in_port;
  logic [31:0] rd_rise, rd_any;
  logic        irq_rise, irq_any;

  always #5 clk = ~clk;

  base_hps_pio_in #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(0), .IRQ_MASK_RST(8'h00)) u_rise (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .readdata(rd_rise), .in_port(in_port), .irq(irq_rise)
  );

  base_hps_pio_in #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(2), .IRQ_MASK_RST(MRST_ANY)) u_any (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .readdata(rd_any), .in_port(in_port), .irq(irq_any)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Scoreboard queues: {any, rise}
  logic [63:0] rd_q[$];
  logic [1:0]  irq_q[$];

  // Reference model. hist holds the input values sampled at the last S+1 edges,
  // oldest first: hist[1] is what the port currently shows, hist[0] the value
  // one cycle earlier.
  logic [7:0] hist [0:S];
  logic [7:0] m_cap  [2];
  logic [7:0] m_mask [2];
  logic [7:0] cur;

  function automatic logic [31:0] exp_rd(int k, logic [1:0] a);
    case (a)
      2'd0:    return {24'h0, hist[1]};
      2'd1:    return {24'h0, m_mask[k]};
      2'd3:    return {24'h0, m_cap[k]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_step();
    logic [7:0] det, clr;
    if (reset) begin
      for (int i = 0; i <= S; i++) hist[i] = 8'h00;
      m_cap[0]  = 8'h00;
      m_cap[1]  = 8'h00;
      m_mask[0] = 8'h00;
      m_mask[1] = MRST_ANY;
    end else begin
      if (chipselect && !read_n)
        rd_q.push_back({exp_rd(1, address), exp_rd(0, address)});
      clr = (chipselect && !write_n && address == 2'd3) ? writedata[7:0] : 8'h00;
      for (int k = 0; k < 2; k++) begin
        // instance 0 reports rising edges, instance 1 reports any change
        det = (k == 0) ? (hist[1] & ~hist[0]) : (hist[1] ^ hist[0]);
        m_cap[k] = det | (m_cap[k] & ~clr);
        if (chipselect && !write_n && address == 2'd1) m_mask[k] = writedata[7:0];
      end
      for (int i = 0; i < S; i++) hist[i] = hist[i+1];
      hist[S] = in_port;
    end
    irq_q.push_back({|(m_cap[1] & m_mask[1]), |(m_cap[0] & m_mask[0])});
  endfunction

  task automatic bus(input logic rst, input logic cs, input logic rd, input logic wr,
                     input logic [1:0] a, input logic [31:0] wd, input logic [7:0] inp);
    @(negedge clk);
    reset      = rst;
    chipselect = cs;
    read_n     = ~rd;
    write_n    = ~wr;
    address    = a;
    writedata  = wd;
    in_port    = inp;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, cur);
  endtask

  task automatic rd_reg(input logic [1:0] a);
    bus(1'b0, 1'b1, 1'b1, 1'b0, a, 32'h0, cur);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    bus(1'b0, 1'b1, 1'b0, 1'b1, a, d, cur);
  endtask

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: a read strobe accepted at an edge yields readdata just after it;
  // irq is compared every cycle against the model's prediction.
  logic        mon_rd;
  logic [63:0] e_rd;
  logic [1:0]  e_irq;
  always @(posedge clk) begin
    mon_rd = (chipselect === 1'b1) && (read_n === 1'b0) && (reset === 1'b0);
    #1;
    if (mon_rd) begin
      if (rd_q.size() == 0) begin
        check("rd_q_underflow", 32'h1, 32'h0);
      end else begin
        e_rd = rd_q.pop_front();
        check("readdata_rise", rd_rise, e_rd[31:0]);
        check("readdata_any",  rd_any,  e_rd[63:32]);
      end
    end
    if (irq_q.size() > 0) begin
      e_irq = irq_q.pop_front();
      check("irq_rise", {31'h0, irq_rise}, {31'h0, e_irq[0]});
      check("irq_any",  {31'h0, irq_any},  {31'h0, e_irq[1]});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
    address = 2'd0; writedata = 32'h0; in_port = 8'h00;
    for (int i = 0; i <= S; i++) hist[i] = 8'h00;
    m_cap[0] = 8'h00; m_cap[1] = 8'h00; m_mask[0] = 8'h00; m_mask[1] = MRST_ANY;

    // Reset state and DATA read with a stable input
    cur = 8'hA5;
    bus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, cur);
    bus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, cur);
    rd_reg(2'd3);
    rd_reg(2'd1);
    idle(4);
    rd_reg(2'd0);
    rd_reg(2'd2);
    wr_reg(2'd2, 32'hFFFF_FFFF);
    wr_reg(2'd0, 32'hFFFF_FFFF);
    rd_reg(2'd2);

    // Rising edge on bit0 with mask 0x01
    cur = 8'h00;
    idle(4);
    wr_reg(2'd3, 32'hFF);
    wr_reg(2'd1, 32'h01);
    cur = 8'h01;
    idle(S + 2);
    rd_reg(2'd3);

    // Clear, then a falling edge is ignored in rising-only mode
    wr_reg(2'd3, 32'h01);
    idle(1);
    cur = 8'h00;
    idle(S + 2);
    rd_reg(2'd3);
    wr_reg(2'd3, 32'hFF);

    // Clear of bit3 lands on the same edge that captures a new rising edge on bit3
    wr_reg(2'd1, 32'h08);
    cur = 8'h08;
    idle(S + 2);
    cur = 8'h00;
    idle(S + 2);
    wr_reg(2'd3, 32'h08);
    cur = 8'h08;
    idle(1);
    idle(S - 1);
    wr_reg(2'd3, 32'h08);
    rd_reg(2'd3);
    idle(2);

    // Any-edge with mask 0, then unmask bit7
    wr_reg(2'd1, 32'h00);
    wr_reg(2'd3, 32'hFF);
    cur = cur ^ 8'h80;
    idle(S + 2);
    rd_reg(2'd3);
    wr_reg(2'd1, 32'h80);
    idle(2);
    rd_reg(2'd1);

    // Reset with an edge still in the synchronizer
    wr_reg(2'd3, 32'hFF);
    cur = cur ^ 8'h40;
    idle(1);
    bus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, cur);
    idle(S + 4);
    rd_reg(2'd1);
    rd_reg(2'd3);
    rd_reg(2'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic r_rst, r_cs, r_rd, r_wr;
      logic [1:0] r_a;
      logic [31:0] r_wd;
      r_rst = ($urandom_range(0, 63) == 0);
      r_cs  = ($urandom_range(0, 3) != 0);
      r_rd  = $urandom_range(0, 1) == 1;
      r_wr  = ($urandom_range(0, 2) == 0);
      r_a   = 2'($urandom_range(0, 3));
      r_wd  = $urandom;
      if ($urandom_range(0, 2) == 0) cur = cur ^ 8'($urandom);
      bus(r_rst, r_cs, r_rd, r_wr, r_a, r_wd, cur);
    end
    idle(3);
    check("rd_q_drained", rd_q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
